uart_tx_drain: RTL and testbench

// - Serial UART transmitter that drains the byte FIFO sitting directly upstream.
// - Pops one word when the FIFO is non-empty and transmits it as an 8N1-style frame on a single tx line.
// - The FIFO's data_out is show-ahead: its data is valid whenever empty=0, and the word is consumed on pop.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_drain_if.sv | 23 ++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_tx_drain.sv | 128 ++++++++++++
 tb/tb_uart_tx_drain.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Show-ahead FIFO read port between an upstream byte FIFO and the UART drainer.
// Handshake: fifo_data is valid whenever fifo_empty=0; a word transfers on any rising
// clk edge where fifo_pop=1, and the consumer asserts fifo_pop only while fifo_empty=0.
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_end marks the last clk cycle of a serial bit; clear restarts it.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops words from a show-ahead FIFO and sends 8N1-style frames.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    uart_tx_drain_if.slave        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output uart_tx_state_t        dbg_state
);

    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    uart_tx_state_t        state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IW-1:0]         bit_idx;
    logic                  bit_end;
    logic                  baud_clear;
    logic                  start_frame;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    // Pop is combinational so the word is consumed on the same edge it is latched.
    assign start_frame   = (state == IDLE) && tx_en && !fifo.fifo_empty && !reset;
    assign fifo.fifo_pop = start_frame;

    // Counter is held clear in IDLE and restarted at every bit boundary.
    assign baud_clear = (state == IDLE) || bit_end;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && (bit_idx == LAST_STOP) && bit_end;
    assign dbg_state  = state;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start_frame) begin
                        shift_reg <= fifo.fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo.fifo_data;
`endif
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shift_reg[1];
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx      <= 1'b1;
                        bit_idx <= '0;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: a FIFO model feeds words, a line monitor checks every frame
// cycle-by-cycle against frames built from the pushed words. Honours UART_TX_PARITY_EN.
module tb_uart_tx_drain;
    import uart_pkg::*;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS     = 1 + DW + PB + SB;
    localparam int FRAME_LEN = NBITS * CPB;
    localparam int POP_GAP   = FRAME_LEN + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           tx_en = 1'b0;
    logic           tx;
    logic           busy;
    logic           frame_done;
    uart_tx_state_t dbg_state;

    uart_tx_drain_if #(.DATA_WIDTH(DW)) fifo_if ();

    uart_tx_drain #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo       (fifo_if.slave),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int pop_count = 0;
    int pop_cycles[$];
    int idle_viol = 0;
    int pop_viol  = 0;
    bit consumed  = 1'b0;

    bit            in_frame = 1'b0;
    int            fcyc = 0;
    int            tx_err, busy_err, done_hits, done_at;
    logic [DW-1:0] cur_word;
    logic          exp_bits[NBITS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((fifo_q.size() != 0 || in_frame || busy) && n < budget) begin
            tick(1);
            n++;
        end
        check({"drain_", name}, (n < budget), 1);
    endtask

    // ---------------- upstream FIFO model (show-ahead) ----------------
    initial begin
        fifo_if.fifo_empty = 1'b1;
        fifo_if.fifo_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (consumed) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                consumed = 1'b0;
            end
            fifo_if.fifo_empty = (fifo_q.size() == 0);
            fifo_if.fifo_data  = (fifo_q.size() == 0) ? DW'($urandom) : fifo_q[0];
        end
    end

    // ---------------- line monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                if (fifo_if.fifo_pop) pop_viol++;
                in_frame = 1'b0;
            end else if (in_frame) begin
                fcyc++;
                if (tx !== exp_bits[(fcyc - 1) / CPB]) tx_err++;
                if (busy !== 1'b1) busy_err++;
                if (fifo_if.fifo_pop) pop_viol++;
                if (frame_done === 1'b1) begin
                    done_hits++;
                    done_at = fcyc;
                end
                if (fcyc == FRAME_LEN) begin
                    check($sformatf("frame_tx_%02h", cur_word), tx_err, 0);
                    check($sformatf("frame_busy_%02h", cur_word), busy_err, 0);
                    check($sformatf("frame_done_pulses_%02h", cur_word), done_hits, 1);
                    check($sformatf("frame_done_at_%02h", cur_word), done_at, FRAME_LEN);
                    in_frame = 1'b0;
                end
            end else begin
                if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) idle_viol++;
                if (fifo_if.fifo_pop) begin
                    if (fifo_if.fifo_empty || !tx_en) pop_viol++;
                    consumed = 1'b1;
                    pop_count++;
                    pop_cycles.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pop: got pop with no word expected, want none");
                    end else begin
                        cur_word = exp_q.pop_front();
                        exp_bits[0] = 1'b0;
                        for (int i = 0; i < DW; i++) exp_bits[1 + i] = cur_word[i];
`ifdef UART_TX_PARITY_EN
                        exp_bits[1 + DW] = ^cur_word;
`endif
                        for (int s = 0; s < SB; s++) exp_bits[1 + DW + PB + s] = 1'b1;
                        in_frame  = 1'b1;
                        fcyc      = 0;
                        tx_err    = 0;
                        busy_err  = 0;
                        done_hits = 0;
                        done_at   = -1;
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        bad++;
        $display("FAIL watchdog: got no finish within time limit, want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        int npush;

        reset = 1'b1;
        tx_en = 1'b0;
        tick(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_pop", fifo_if.fifo_pop, 0);
        check("rst_state", dbg_state, IDLE);

        // Idle with empty FIFO
        reset = 1'b0;
        tx_en = 1'b1;
        tick(100);
        check("idle_viol", idle_viol, 0);
        check("idle_pops", pop_count, 0);

        // Single bytes
        push(8'hA5);
        wait_drain(200, "a5");
        check("a5_pops", pop_count, 1);
        push(8'h07);
        wait_drain(200, "07");
        check("07_pops", pop_count, 2);

        // Back-to-back from a preloaded FIFO
        tx_en = 1'b0;
        push(8'h00);
        push(8'hFF);
        tick(3);
        tx_en = 1'b1;
        wait_drain(300, "b2b");
        check("b2b_gap", pop_cycles[pop_cycles.size() - 1] - pop_cycles[pop_cycles.size() - 2], POP_GAP);

        // tx_en dropped mid-DATA with a second word pending
        base = pop_count;
        push(8'h3C);
        push(8'h5A);
        n = 0;
        while (!(in_frame && fcyc >= 10) && n < 60) begin tick(1); n++; end
        check("txen_reached_data", (n < 60), 1);
        tx_en = 1'b0;
        n = 0;
        while (in_frame && n < 80) begin tick(1); n++; end
        tick(30);
        check("txen_hold_pops", pop_count - base, 1);
        check("txen_fifo_left", fifo_q.size(), 1);
        tx_en = 1'b1;
        wait_drain(200, "txen");
        check("txen_resume_pops", pop_count - base, 2);

        // Reset during data bit 3 of 0x81
        base = pop_count;
        push(8'h81);
        n = 0;
        while (!(in_frame && fcyc >= 18) && n < 60) begin tick(1); n++; end
        check("rst_mid_reached_bit3", (n < 60), 1);
        push(8'h42);
        reset = 1'b1;
        tick(1);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        tick(4);
        check("rst_mid_no_pop", pop_count - base, 1);
        reset = 1'b0;
        wait_drain(200, "rst_mid");
        check("rst_mid_pops", pop_count - base, 2);

        // Random traffic with random tx_en gating
        npush = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) tx_en = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) != 0) begin
                push(DW'($urandom));
                npush++;
            end
            tick($urandom_range(0, 30));
        end
        tx_en = 1'b1;
        base = pop_count;
        wait_drain(50 * POP_GAP, "random");

        tick(5);
        check("exp_q_empty", exp_q.size(), 0);
        check("fifo_q_empty", fifo_q.size(), 0);
        check("pop_viol", pop_viol, 0);
        check("idle_viol_total", idle_viol, 0);
        check("random_pushed_some", (npush > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
